// File: rtl/cpu_pkg.sv
// Shared types for the QUAD.nibble datapath: ALU opcodes, flag bundle, default width.
// Overflow helpers are kept here so every arithmetic unit applies the same sign rules.
package cpu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_NOR   = 4'h5,
        OP_SLL   = 4'h6,
        OP_SRL   = 4'h7,
        OP_SRA   = 4'h8,
        OP_ROL   = 4'h9,
        OP_ROR   = 4'hA,
        OP_SLT   = 4'hB,
        OP_SLTU  = 4'hC,
        OP_PASSA = 4'hD,
        OP_PASSB = 4'hE,
        OP_MUL   = 4'hF
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    // Signed overflow on A+B: same operand signs, result sign flipped.
    function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

    // Signed overflow on A-B: operand signs differ, result sign differs from A.
    function automatic logic sub_ovf(input logic sign_a, input logic sign_b, input logic sign_r);
        return (sign_a != sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/cpu_alu_if.sv
// Operand/opcode/result bundle between the control unit, register file and the ALU.
interface cpu_alu_if #(
    parameter int WIDTH = cpu_pkg::ALU_WIDTH
);
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output alu_ctrl, op_a, op_b,
        input  result, flag_z, flag_n, flag_c, flag_v
    );

    modport slave (
        input  alu_ctrl, op_a, op_b,
        output result, flag_z, flag_n, flag_c, flag_v
    );
endinterface

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA/ROL/ROR; carry is the last bit pushed out.
// Shifts use a one-bit guard extension so the carry falls out of the same shift operation.
module alu_shifter
    import cpu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  alu_op_e            op,
    input  logic [WIDTH-1:0]   value,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   shifted,
    output logic               carry
);

    logic [WIDTH:0]   sll_s;
    logic [WIDTH:0]   srl_s;
    logic [WIDTH:0]   sra_s;
    logic [SHAMT_W:0] inv_s;
    logic [WIDTH-1:0] rol_s;
    logic [WIDTH-1:0] ror_s;
    logic             nz_s;

    assign sll_s = {1'b0, value} << shamt;
    assign srl_s = {value, 1'b0} >> shamt;
    assign sra_s = $signed({value, 1'b0}) >>> shamt;
    // WIDTH is a power of two, so WIDTH - shamt fits in SHAMT_W+1 bits; shamt=0 makes the wrap term vanish.
    assign inv_s = {1'b1, {SHAMT_W{1'b0}}} - {1'b0, shamt};
    assign rol_s = (value << shamt) | (value >> inv_s);
    assign ror_s = (value >> shamt) | (value << inv_s);
    assign nz_s  = |shamt;

    // Select shifted value and carry for the requested shift/rotate.
    always_comb begin
        shifted = value;
        carry   = 1'b0;
        case (op)
            OP_SLL: begin
                shifted = sll_s[WIDTH-1:0];
                carry   = sll_s[WIDTH];
            end
            OP_SRL: begin
                shifted = srl_s[WIDTH:1];
                carry   = srl_s[0];
            end
            OP_SRA: begin
                shifted = sra_s[WIDTH:1];
                carry   = sra_s[0];
            end
            OP_ROL: begin
                shifted = rol_s;
                carry   = nz_s & rol_s[0];
            end
            OP_ROR: begin
                shifted = ror_s;
                carry   = nz_s & ror_s[WIDTH-1];
            end
            default: begin
                shifted = value;
                carry   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_alu.sv
// Registered integer ALU (result + Z/N/C/V) with one-cycle latency.
// Optional macro ALU_MUL_EN turns opcode F into a signed multiply; otherwise F is PASSA.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      resetn,
    cpu_alu_if.slave bus
);

    alu_op_e          op_s;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] shift_res_s;
    logic             shift_c_s;
    logic [WIDTH-1:0] res_s;
    alu_flags_t       flags_s;
    logic [WIDTH-1:0] result_r;
    alu_flags_t       flags_r;

    assign op_s   = alu_op_e'(bus.alu_ctrl);
    assign a_s    = bus.op_a;
    assign b_s    = bus.op_b;
    assign sum_s  = {1'b0, a_s} + {1'b0, b_s};
    // Top bit of the extended difference is the borrow; carry reports its absence.
    assign diff_s = {1'b0, a_s} - {1'b0, b_s};

`ifdef ALU_MUL_EN
    logic signed [2*WIDTH-1:0] prod_s;
    assign prod_s = $signed(a_s) * $signed(b_s);
`endif

    alu_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .op      (op_s),
        .value   (a_s),
        .shamt   (b_s[SHAMT_W-1:0]),
        .shifted (shift_res_s),
        .carry   (shift_c_s)
    );

    // Next result and flags from the current operands and opcode.
    always_comb begin
        res_s     = a_s;
        flags_s.z = 1'b0;
        flags_s.n = 1'b0;
        flags_s.c = 1'b0;
        flags_s.v = 1'b0;
        case (op_s)
            OP_ADD: begin
                res_s     = sum_s[WIDTH-1:0];
                flags_s.c = sum_s[WIDTH];
                flags_s.v = add_ovf(a_s[WIDTH-1], b_s[WIDTH-1], sum_s[WIDTH-1]);
            end
            OP_SUB: begin
                res_s     = diff_s[WIDTH-1:0];
                flags_s.c = ~diff_s[WIDTH];
                flags_s.v = sub_ovf(a_s[WIDTH-1], b_s[WIDTH-1], diff_s[WIDTH-1]);
            end
            OP_AND:   res_s = a_s & b_s;
            OP_OR:    res_s = a_s | b_s;
            OP_XOR:   res_s = a_s ^ b_s;
            OP_NOR:   res_s = ~(a_s | b_s);
            OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: begin
                res_s     = shift_res_s;
                flags_s.c = shift_c_s;
            end
            OP_SLT:   res_s = {{(WIDTH-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
            OP_SLTU:  res_s = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_PASSA: res_s = a_s;
            OP_PASSB: res_s = b_s;
            OP_MUL: begin
`ifdef ALU_MUL_EN
                res_s     = prod_s[WIDTH-1:0];
                flags_s.v = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
`else
                res_s     = a_s;
`endif
            end
            default: res_s = a_s;
        endcase
        flags_s.z = (res_s == {WIDTH{1'b0}});
        flags_s.n = res_s[WIDTH-1];
    end

    // Output register; reset (active high) wins over the operation on the same edge.
    always_ff @(posedge clk) begin
        if (resetn) begin
            result_r <= {WIDTH{1'b0}};
            flags_r  <= alu_flags_t'(4'b0000);
        end else begin
            result_r <= res_s;
            flags_r  <= flags_s;
        end
    end

    assign bus.result = result_r;
    assign bus.flag_z = flags_r.z;
    assign bus.flag_n = flags_r.n;
    assign bus.flag_c = flags_r.c;
    assign bus.flag_v = flags_r.v;

endmodule

// File: tb/tb_cpu_alu.sv
// Self-checking bench for cpu_alu: directed vectors with literal expectations plus an
// arithmetic reference model compared against the outputs every cycle.
module tb_cpu_alu;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    cpu_alu_if #(.WIDTH(16)) bus ();

    cpu_alu #(.WIDTH(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference: {result, z, n, c, v} from plain integer arithmetic and bit-at-a-time shifts.
    function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int          sa;
        int          sb;
        int          full;
        int          s;
        logic [15:0] r;
        logic        c;
        logic        v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        s  = int'(b[3:0]);
        r  = a;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            4'h0: begin
                full = int'(a) + int'(b);
                r = full[15:0];
                c = full[16];
                v = (sa + sb > 32767) || (sa + sb < -32768);
            end
            4'h1: begin
                r = a - b;
                c = (a >= b);
                v = (sa - sb > 32767) || (sa - sb < -32768);
            end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = ~(a | b);
            4'h6: for (int i = 0; i < s; i++) begin c = r[15]; r = {r[14:0], 1'b0}; end
            4'h7: for (int i = 0; i < s; i++) begin c = r[0];  r = {1'b0, r[15:1]}; end
            4'h8: for (int i = 0; i < s; i++) begin c = r[0];  r = {r[15], r[15:1]}; end
            4'h9: for (int i = 0; i < s; i++) begin c = r[15]; r = {r[14:0], r[15]}; end
            4'hA: for (int i = 0; i < s; i++) begin c = r[0];  r = {r[0], r[15:1]}; end
            4'hB: r = (sa < sb) ? 16'd1 : 16'd0;
            4'hC: r = (a < b) ? 16'd1 : 16'd0;
            4'hD: r = a;
            4'hE: r = b;
            4'hF: begin
`ifdef ALU_MUL_EN
                full = sa * sb;
                r = full[15:0];
                v = (full > 32767) || (full < -32768);
`else
                r = a;
`endif
            end
            default: r = a;
        endcase
        return {r, (r == 16'd0), r[15], c, v};
    endfunction

    logic [19:0] exp_q;
    logic        exp_valid = 1'b0;

    // Model what the outputs must hold after each rising edge.
    always @(posedge clk) begin
        if (resetn) exp_q <= 20'h0;
        else        exp_q <= model(bus.alu_ctrl, bus.op_a, bus.op_b);
        exp_valid <= 1'b1;
    end

    // Compare outputs with the model mid-cycle.
    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if ({bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== exp_q) begin
                errors++;
                $display("FAIL model: got res=%h zncv=%b%b%b%b, want res=%h zncv=%b",
                         bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v,
                         exp_q[19:4], exp_q[3:0]);
            end
        end
    end

    task automatic vec(input string name, input logic rst, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic [3:0] ef);
        resetn       = rst;
        bus.alu_ctrl = op;
        bus.op_a     = a;
        bus.op_b     = b;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.result !== er || {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== ef) begin
            errors++;
            $display("FAIL %s: got res=%h zncv=%b%b%b%b, want res=%h zncv=%b", name,
                     bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, er, ef);
        end
        if (!rst) begin
            checks++;
            if (model(op, a, b) !== {er, ef}) begin
                errors++;
                $display("FAIL %s model-pin: got %h, want %h", name, model(op, a, b), {er, ef});
            end
        end
    endtask

    initial begin
        resetn       = 1'b1;
        bus.alu_ctrl = 4'h0;
        bus.op_a     = 16'd5;
        bus.op_b     = 16'd3;
        @(negedge clk);
        vec("reset0",   1'b1, 4'h0, 16'd5,    16'd3,    16'h0000, 4'b0000);
        vec("reset1",   1'b1, 4'h0, 16'd5,    16'd3,    16'h0000, 4'b0000);
        vec("add",      1'b0, 4'h0, 16'd5,    16'd3,    16'h0008, 4'b0000);
        vec("add_ovf",  1'b0, 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
        vec("add_wrap", 1'b0, 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
        vec("sub_brw",  1'b0, 4'h1, 16'd3,    16'd5,    16'hFFFE, 4'b0100);
        vec("sub_eq",   1'b0, 4'h1, 16'd5,    16'd5,    16'h0000, 4'b1010);
        vec("sub_ovf",  1'b0, 4'h1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011);
        vec("sra",      1'b0, 4'h8, 16'h8001, 16'h0001, 16'hC000, 4'b0110);
        vec("rol",      1'b0, 4'h9, 16'h8001, 16'h0004, 16'h0018, 4'b0000);
        vec("sll0",     1'b0, 4'h6, 16'h1234, 16'h0010, 16'h1234, 4'b0000);
        vec("sll15",    1'b0, 4'h6, 16'h0003, 16'h000F, 16'h8000, 4'b0110);
        vec("srl15",    1'b0, 4'h7, 16'h8001, 16'h000F, 16'h0001, 4'b0000);
        vec("ror1",     1'b0, 4'hA, 16'h0001, 16'h0001, 16'h8000, 4'b0110);
        vec("slt",      1'b0, 4'hB, 16'hFFFF, 16'h0001, 16'h0001, 4'b0000);
        vec("sltu",     1'b0, 4'hC, 16'hFFFF, 16'h0001, 16'h0000, 4'b1000);
        vec("nor",      1'b0, 4'h5, 16'h0000, 16'h0000, 16'hFFFF, 4'b0100);
        vec("xor",      1'b0, 4'h4, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000);
        vec("and",      1'b0, 4'h2, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100);
        vec("or",       1'b0, 4'h3, 16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000);
        vec("passb",    1'b0, 4'hE, 16'h0000, 16'h8000, 16'h8000, 4'b0100);
`ifdef ALU_MUL_EN
        vec("op_f",     1'b0, 4'hF, 16'd300,  16'd300,  16'h5F90, 4'b0001);
`else
        vec("op_f",     1'b0, 4'hF, 16'd300,  16'd300,  16'h012C, 4'b0000);
`endif
        vec("rst_mid",  1'b1, 4'h1, 16'd3,    16'd5,    16'h0000, 4'b0000);
        resetn = 1'b0;
        for (int i = 0; i < 96; i++) begin
            bus.alu_ctrl = 4'(i % 16);
            bus.op_a     = 16'($urandom);
            bus.op_b     = (i < 48) ? 16'($urandom) : 16'($urandom_range(0, 17));
            @(negedge clk);
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_alu.md
Name: cpu_alu

Overview:
- Registered integer ALU for the QUAD.nibble CPU datapath, instantiated as `alu` inside the CPU core.
- Takes two signed operands and a 4-bit operation code and produces a result plus four status flags (Z, N, C, V).
- Outputs update one clock after the inputs are sampled. The control unit drives `alu_ctrl`; the register file drives `op_a` and `op_b`.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a power of two, minimum 8.
- SHAMT_W, $clog2(WIDTH), shift-amount width taken from the low bits of op_b.

Ports:
- clk  input  1  sole clock; everything samples on the rising edge.
- resetn  input  1  synchronous, active-high reset (codebase port name retained; asserted = 1).
- alu_ctrl  input  4  operation select.
- op_a  input  WIDTH  signed operand A.
- op_b  input  WIDTH  signed operand B; low SHAMT_W bits are the shift amount for shifts and rotates.
- result  output  WIDTH  registered result.
- flag_z  output  1  registered zero flag.
- flag_n  output  1  registered negative flag.
- flag_c  output  1  registered carry flag.
- flag_v  output  1  registered signed-overflow flag.

Behaviour:
- Reset: on a rising edge with resetn=1, result=0 and all four flags=0. Reset has priority over any operation and overrides an operation presented on the same edge.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N. No handshake; a new operation is accepted every cycle and the outputs update every cycle.
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOR.
  - 6 SLL: A<<s.
  - 7 SRL: logical right shift.
  - 8 SRA: arithmetic right shift.
  - 9 ROL.
  - A ROR.
  - B SLT: 1 if A<B signed, else 0.
  - C SLTU: 1 if A<B unsigned, else 0.
  - D PASSA: result=A.
  - E PASSB: result=B.
  - F MUL: low WIDTH bits of A*B, only with the optional feature; otherwise F behaves as PASSA.
- Arithmetic is modulo 2^WIDTH and wraps silently. No exceptions or traps.
- flag_z = (result==0).
- flag_n = result[WIDTH-1].
- flag_c rules:
  - ADD: carry out of the MSB.
  - SUB: 1 when there is NO borrow (A>=B unsigned).
  - SLL/ROL: last bit shifted out of the MSB end.
  - SRL/SRA/ROR: last bit shifted out of the LSB end.
  - Shift or rotate by 0: C=0.
  - All other ops: C=0.
- flag_v rules:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from A.
  - All other ops: V=0.
- Boundaries:
  - Shift amount uses only op_b[SHAMT_W-1:0]; higher bits are ignored.
  - Rotate by 0 returns A unchanged.
  - SRA of a negative value fills with 1s.
  - Unknown or undefined opcodes cannot occur (all 16 are decoded).
- Implementation structure: combinational next-state from the current inputs, registered in a single always_ff block.

Optional Feature:
- Macro ALU_MUL_EN.
- When defined: opcode F computes the low WIDTH bits of a signed A*B, still with 1-cycle latency. Z and N are derived from the result; C=0; V=1 when the full 2*WIDTH product does not sign-extend from WIDTH bits.
- When undefined: no multiplier is synthesised and opcode F behaves exactly as PASSA, including its flags.

Decomposition:
- Shared package cpu_pkg holds:
  - The alu_op_e enum (4-bit, values 0–F as listed above).
  - The WIDTH default constant.
  - A flags struct alu_flags_t {z,n,c,v}.
- One natural sub-module, alu_shifter: a combinational barrel shifter covering SLL/SRL/SRA/ROL/ROR. It outputs the shifted value and the carry-out, and is instantiated once.

Test Plan:
- Reset: hold resetn=1 with alu_ctrl=ADD, A=5, B=3 for 2 cycles -> result=0 and all flags 0. Deassert reset -> next cycle result=8.
- ADD overflow: A=16'h7FFF, B=16'h0001 -> result=16'h8000, N=1, V=1, C=0, Z=0. Then A=16'hFFFF, B=16'h0001 -> result=0, Z=1, C=1, V=0.
- SUB: A=3, B=5 -> result=16'hFFFE, N=1, C=0 (borrow). A=5, B=5 -> result=0, Z=1, C=1.
- Shifts: SRA with A=16'h8001, B=1 -> result=16'hC000, C=1. ROL with A=16'h8001, B=4 -> result=16'h0018, C=0. SLL with B=16'h0010 (amount 0) -> result=A, C=0.
- Compare: SLT with A=16'hFFFF, B=1 -> 1. SLTU with the same operands -> 0.
- Opcode F: with ALU_MUL_EN, A=300, B=300 -> result=16'h5F90, V=1. Without it -> result=300.
